// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// default datapath sizing.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/busy/done handshake plus operand and result bus of the serial adder.
// The requester uses the master modport, the adder the slave modport.
interface serial_adder_ctrl_if
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, overflow
  );

endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// The team's 1-bit full-adder cell; the only arithmetic element of the
// serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic product,
  output logic c_out
);

  assign product = a ^ b ^ c_in;
  assign c_out   = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per cycle, LSB first,
// through a single full-adder cell, with a start/busy/done handshake.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  full_adder u_fa (
    .a       (a_sh[0]),
    .b       (b_sh[0]),
    .c_in    (carry),
    .product (fa_sum),
    .c_out   (fa_cout)
  );

  // Written as shift-then-insert so the same code covers WIDTH=1.
  always_comb begin
    s_next            = s_sh >> 1;
    s_next[WIDTH-1]   = fa_sum;
  end

  assign last_bit = (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_sh         <= '0;
      b_sh         <= '0;
      s_sh         <= '0;
      carry        <= 1'b0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.sum      <= '0;
      bus.c_out    <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            carry    <= bus.c_in;
            cnt      <= '0;
            s_sh     <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          s_sh  <= s_next;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_cout;
          cnt   <= cnt + CNT_W'(1);
          // carry still holds the carry into the MSB on the final edge.
          if (last_bit) begin
            bus.sum      <= s_next;
            bus.c_out    <= fa_cout;
            bus.overflow <= carry ^ fa_cout;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1 against an
// arithmetic reference model.
module tb_serial_adder_ctrl;
  import serial_adder_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_adder_ctrl #(.WIDTH(8), .CNT_W(5)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  serial_adder_ctrl #(.WIDTH(1), .CNT_W(5)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Last committed result per DUT, {c_out, overflow, sum}; index 0 is WIDTH=1.
  logic [33:0] prev_res [2];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs [7];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input int w);
    return (w == 1) ? bus1.busy : bus8.busy;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 1) ? bus1.done : bus8.done;
  endfunction

  function automatic logic [33:0] get_res(input int w);
    if (w == 1) return {bus1.c_out, bus1.overflow, 31'b0, bus1.sum};
    return {bus8.c_out, bus8.overflow, 24'b0, bus8.sum};
  endfunction

  // {c_out, sum} = a + b + c_in modulo 2**(w+1); overflow by the sign rule.
  function automatic logic [33:0] model(input int w, input logic [31:0] av,
                                        input logic [31:0] bv, input logic ci);
    logic [32:0] mask;
    logic [32:0] tot;
    logic [31:0] s;
    logic        co;
    logic        ov;
    mask = (33'd1 << w) - 33'd1;
    tot  = ({1'b0, av} & mask) + ({1'b0, bv} & mask) + 33'(ci);
    s    = tot[31:0] & mask[31:0];
    co   = tot[w];
    ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    return {co, ov, s};
  endfunction

  task automatic drive(input int w, input logic st, input logic [31:0] av,
                       input logic [31:0] bv, input logic ci);
    if (w == 1) begin
      bus1.start = st;
      bus1.a     = av[0];
      bus1.b     = bv[0];
      bus1.c_in  = ci;
    end else begin
      bus8.start = st;
      bus8.a     = av[7:0];
      bus8.b     = bv[7:0];
      bus8.c_in  = ci;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic apply_stimulus(input int w, input logic [31:0] av, input logic [31:0] bv,
                                input logic ci, output logic [33:0] got);
    int          k;
    logic [33:0] held;
    logic        run_ok;
    k      = (w == 1) ? 0 : 1;
    held   = prev_res[k];
    run_ok = 1'b1;
    drive(w, 1'b1, av, bv, ci);
    @(posedge clk);
    for (int t = 0; t < w; t++) begin
      @(negedge clk);
      if (t == 0) drive(w, 1'b0, $urandom, $urandom, 1'($urandom));
      if (get_busy(w) !== 1'b1 || get_done(w) !== 1'b0 || get_res(w) !== held)
        run_ok = 1'b0;
    end
    check_output($sformatf("run_window_w%0d", w), 64'(run_ok), 64'd1);
    @(negedge clk);
    check_output($sformatf("done_at_w_edges_w%0d", w), 64'({get_done(w), get_busy(w)}), 64'd2);
    got         = get_res(w);
    prev_res[k] = model(w, av, bv, ci);
    @(negedge clk);
    check_output($sformatf("done_one_cycle_w%0d", w), 64'(get_done(w)), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [33:0] got;
    logic [33:0] exp;
    logic [31:0] x1, y1, x2, y2, av, bv;
    logic        ci;
    int          done_cnt;
    logic        pos_ok;
    logic        seen;

    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b1;
    drive(8, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0);
    #1 rst_n = 1'b0;
    prev_res[0] = '0;
    prev_res[1] = '0;
    repeat (2) @(negedge clk);
    check_output("reset_w8", 64'({get_busy(8), get_done(8), get_res(8)}), 64'd0);
    check_output("reset_w1", 64'({get_busy(1), get_done(1), get_res(1)}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(8, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].ci, got);
      check_output($sformatf("vec%0d", i), 64'(got),
                   64'({vecs[i].co, vecs[i].ov, 24'b0, vecs[i].s}));
    end

    // Reset during the 4th RUN cycle: outputs clear at once, no done follows.
    drive(8, 1'b1, 32'h12, 32'h34, 1'b0);
    @(posedge clk);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (t == 0) drive(8, 1'b0, 32'h12, 32'h34, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check_output("async_reset_clear", 64'({get_busy(8), get_done(8), get_res(8)}), 64'd0);
    prev_res[0] = '0;
    prev_res[1] = '0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen |= get_done(8) | get_busy(8);
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      seen |= get_done(8) | get_busy(8);
    end
    check_output("no_done_after_reset", 64'(seen), 64'd0);
    apply_stimulus(8, 32'h01, 32'h02, 1'b0, got);
    check_output("post_reset_add", 64'(got), 64'h3);

    // start held high, operands toggling: second op starts on first IDLE edge.
    x1 = 32'($urandom_range(0, 255));
    y1 = 32'($urandom_range(0, 255));
    x2 = 32'($urandom_range(0, 255));
    y2 = 32'($urandom_range(0, 255));
    done_cnt = 0;
    pos_ok   = 1'b1;
    drive(8, 1'b1, x1, y1, 1'b0);
    @(posedge clk);
    for (int t = 0; t <= 19; t++) begin
      @(negedge clk);
      if (get_done(8)) done_cnt++;
      if (get_done(8) !== ((t == 8) || (t == 18))) pos_ok = 1'b0;
      if (t == 8) begin
        check_output("held_start_first", 64'(get_res(8)), 64'(model(8, x1, y1, 1'b0)));
        prev_res[1] = model(8, x1, y1, 1'b0);
      end
      if (t == 18) begin
        check_output("held_start_second", 64'(get_res(8)), 64'(model(8, x2, y2, 1'b0)));
        prev_res[1] = model(8, x2, y2, 1'b0);
      end
      if (t == 9)       drive(8, 1'b1, x2, y2, 1'b0);
      else if (t == 19) drive(8, 1'b0, 0, 0, 1'b0);
      else              drive(8, 1'b1, $urandom, $urandom, 1'($urandom));
    end
    check_output("held_start_done_count", 64'(done_cnt), 64'd2);
    check_output("held_start_done_timing", 64'(pos_ok), 64'd1);
    @(negedge clk);
    check_output("start_not_queued", 64'(get_busy(8)), 64'd0);

    for (int i = 0; i < 30; i++) begin
      av  = $urandom;
      bv  = $urandom;
      ci  = 1'($urandom_range(0, 1));
      exp = model(8, av, bv, ci);
      apply_stimulus(8, av, bv, ci, got);
      check_output($sformatf("rand_w8_%0d", i), 64'(got), 64'(exp));
    end

    for (int i = 0; i < 16; i++) begin
      av  = 32'(i[0]);
      bv  = 32'(i[1]);
      ci  = (i < 8) ? i[2] : 1'($urandom_range(0, 1));
      if (i >= 8) begin
        av = $urandom;
        bv = $urandom;
      end
      exp = model(1, av, bv, ci);
      apply_stimulus(1, av, bv, ci, got);
      check_output($sformatf("rand_w1_%0d", i), 64'(got), 64'(exp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder datapath and controller for WIDTH-bit operands.
- Each cycle it feeds one operand bit pair, LSB first, plus a registered carry into a single 1-bit full-adder cell, then shifts the cell's sum bit into a result register.
- Start/busy/done handshake.
- Produces the WIDTH-bit sum, carry-out and two's-complement overflow after WIDTH processing cycles.
- Sits directly upstream of, and wraps, the team's 1-bit full_adder cell.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A; captured on the accepted start edge
- b  in  WIDTH  operand B; captured on the accepted start edge
- c_in  in  1  initial carry; captured on the accepted start edge
- busy  out  1  high while bits are being processed (RUN)
- done  out  1  one-cycle pulse when a result is updated
- sum  out  WIDTH  registered result
- c_out  out  1  carry out of bit WIDTH-1
- overflow  out  1  signed overflow, equal to the carry into the MSB XOR c_out

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - busy, done, sum, c_out and overflow all go to 0.
  - Internal shift registers, carry flop and counter clear.
  - Any in-flight operation is discarded; no done is produced for it.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: load a_sh<=a, b_sh<=b, carry<=c_in, cnt<=0, s_sh<=0; go to RUN.
  - start=0: remain in IDLE.
- RUN:
  - busy=1.
  - Full-adder cell inputs are a_sh[0], b_sh[0], carry.
  - Each edge:
    - s_sh<={fa_sum, s_sh[WIDTH-1:1]}
    - a_sh, b_sh shift right by 1 with zero fill
    - carry<=fa_cout
    - cnt<=cnt+1
  - On the edge where cnt==WIDTH-1:
    - sum<={fa_sum, s_sh[WIDTH-1:1]}
    - c_out<=fa_cout
    - overflow<=carry^fa_cout, where carry is the value before that edge
    - go to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then unconditionally go to IDLE.
- Latency:
  - Start sampled at edge E0.
  - busy is high from E0 to E0+WIDTH.
  - sum, c_out and overflow update at E0+WIDTH.
  - done is high between E0+WIDTH and E0+WIDTH+1.
  - Minimum start-to-start spacing is WIDTH+2 edges.
- start while in RUN or DONE is ignored; it is not queued.
- Changes on a, b or c_in after the accepted start have no effect on the operation in progress.
- sum, c_out and overflow hold their last values through the following IDLE and through the RUN phase of the next operation. They change only at the final RUN edge.
- Arithmetic is modulo 2**WIDTH; c_out is the 1-bit extension of the sum.
- WIDTH=1: RUN lasts one edge; overflow = c_in ^ c_out.
- The full-adder cell is the only arithmetic element. No wide '+' appears in this block.

Decomposition:
- Shared include file holds:
  - State encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Default WIDTH constant.
- One sub-module: the existing 1-bit full_adder cell (a, b, c_in -> product, c_out), instantiated once.
- The FSM, shift registers and counter stay in this module.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, c_in=0 -> sum=0x8D, c_out=0, overflow=1; done exactly 8 edges after the start edge; busy high for those 8 cycles.
- a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, overflow=0. Separately, a=0xFF, b=0x00, c_in=1 -> sum=0x00, c_out=1, overflow=0.
- a=0x80, b=0x80, c_in=0 -> sum=0x00, c_out=1, overflow=1. Separately, a=0x7F, b=0x01 -> sum=0x80, c_out=0, overflow=1.
- Input stability: hold start=1 continuously and toggle a/b during RUN.
  - First operation's result matches the operands captured at start.
  - Second operation begins only after DONE->IDLE: its start edge is the first IDLE edge with start=1.
  - Exactly one done per operation.
- Reset mid-operation: pull rst_n low at the 4th RUN cycle.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - No done appears.
  - After release, a=0x01, b=0x02 -> sum=0x03.
- Sweep WIDTH in {1, 8}: random a, b, c_in against a reference model; every result must equal {c_out,sum}=a+b+c_in, with overflow matching the signed rule.
